fxp_2_fp_stream_block: RTL

- Converts the fixed-point element stream produced by the subtract stage back to IEEE-754 single precision, so downstream FP blocks can consume softmax intermediates.
- Sign-magnitude fixed-point words enter on a valid-only interface and are buffered in an internal FIFO.
- Each word is normalised with an iterative shift FSM, packed to FP32, and presented on a valid/ready output.
- Emits a per-vector done pulse after number_of_data outputs have been accepted.

---
 rtl/fxp_2_fp_stream_block_if.sv | 33 +++
 rtl/fxp_2_fp_stream_block.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fxp_2_fp_stream_block_if.sv
// Stream bundle between the fixed-point producer and the FP32 converter.
// slave = converter side, master = producer/consumer side.
interface fxp_2_fp_stream_if #(
  parameter int data_size = 32
);
  logic [data_size-1:0] fxp_2_fp_data_i;
  logic                 fxp_2_fp_data_valid_i;
  logic                 fxp_2_fp_full_o;
  logic [data_size-1:0] fxp_2_fp_data_o;
  logic                 fxp_2_fp_data_valid_o;
  logic                 fxp_2_fp_data_ready_i;
  logic                 fxp_2_fp_vector_done_o;

  modport slave (
    input  fxp_2_fp_data_i,
    input  fxp_2_fp_data_valid_i,
    output fxp_2_fp_full_o,
    output fxp_2_fp_data_o,
    output fxp_2_fp_data_valid_o,
    input  fxp_2_fp_data_ready_i,
    output fxp_2_fp_vector_done_o
  );

  modport master (
    output fxp_2_fp_data_i,
    output fxp_2_fp_data_valid_i,
    input  fxp_2_fp_full_o,
    input  fxp_2_fp_data_o,
    input  fxp_2_fp_data_valid_o,
    output fxp_2_fp_data_ready_i,
    input  fxp_2_fp_vector_done_o
  );
endinterface

// File: rtl/fxp_2_fp_stream_block.sv
// Sign-magnitude fixed-point to FP32 converter: input FIFO, shift-normalise FSM, valid/ready output.
// Latency: valid_o rises leading-zero-count+2 edges after pop; input writes dropped while full_o.
module fxp_2_fp_stream_block #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int frac_bits      = 16,
  parameter int fifo_depth     = 10
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  fxp_2_fp_stream_if.slave   stream
);

  localparam int MAG_W  = data_size - 1;
  localparam int PTR_W  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CNT_W  = $clog2(fifo_depth + 1);
  localparam int VCNT_W = (number_of_data > 1) ? $clog2(number_of_data) : 1;
  localparam logic [7:0] EXP_BASE = 8'(127 + (MAG_W - 1) - frac_bits);

  typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} state_t;

  logic [data_size-1:0] r_mem [fifo_depth];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_full;

  state_t               r_state;
  logic                 r_sign;
  logic [MAG_W-1:0]     r_mag;
  logic [4:0]           r_shift;
  logic [data_size-1:0] r_data;
  logic                 r_valid;
  logic [VCNT_W-1:0]    r_vec_cnt;
  logic                 r_done;

  logic                 w_push;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [data_size-1:0] w_head;
  logic [7:0]           w_exp;

  // A full FIFO drops the write even if a pop frees a slot on the same edge.
  assign w_push = stream.fxp_2_fp_data_valid_i & ~r_full;
  assign w_pop  = (r_state == IDLE) && (r_count != '0);
  assign w_head = r_mem[r_rd_ptr];
  assign w_exp  = EXP_BASE - {3'b000, r_shift};

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= stream.fxp_2_fp_data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(fifo_depth - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(fifo_depth - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(fifo_depth));
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= IDLE;
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_vec_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_sign  <= w_head[data_size-1];
            r_mag   <= w_head[MAG_W-1:0];
            r_shift <= '0;
            r_state <= NORM;
          end
        end
        NORM: begin
          if ((r_mag == '0) || r_mag[MAG_W-1]) begin
            r_state <= PACK;
          end else begin
            r_mag   <= {r_mag[MAG_W-2:0], 1'b0};
            r_shift <= r_shift + 5'd1;
          end
        end
        PACK: begin
          // Zero magnitude always packs to +0, whatever the latched sign.
          if (r_mag == '0) begin
            r_data <= '0;
          end else begin
            r_data <= {r_sign, w_exp, r_mag[MAG_W-2 -: 23]};
          end
          r_valid <= 1'b1;
          r_state <= HOLD;
        end
        HOLD: begin
          if (stream.fxp_2_fp_data_ready_i) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
            if (r_vec_cnt == VCNT_W'(number_of_data - 1)) begin
              r_vec_cnt <= '0;
              r_done    <= 1'b1;
            end else begin
              r_vec_cnt <= r_vec_cnt + VCNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stream.fxp_2_fp_full_o        = r_full;
  assign stream.fxp_2_fp_data_o        = r_data;
  assign stream.fxp_2_fp_data_valid_o  = r_valid;
  assign stream.fxp_2_fp_vector_done_o = r_done;

endmodule
